// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: bundle widths, one-hot ALU op bit indices and bundle layouts shared by EX, ID and MEM
package ex_stage_pkg;
    localparam int ID_TO_EX_WIDTH  = 161;
    localparam int EX_TO_MEM_WIDTH = 110;
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        ld_w;
        logic        st_b;
        logic        st_h;
        logic        st_w;
        logic        mul_w;
        logic        mulh_w;
        logic        mulh_wu;
        logic        div_w;
        logic        mod_w;
        logic        div_wu;
        logic        mod_wu;
    } id_to_ex_t;
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        ld_w;
        logic        res_from_mul;
        logic        mul_h;
        logic        res_from_div;
        logic [31:0] div_result;
    } ex_to_mem_t;
endpackage

// File: rtl/ex_div_iter.sv
// ex_div_iter: iterative restoring divider, one quotient bit per cycle on magnitudes, signs fixed at the output
// Ports: clk, resetn (async active-low); start loads operands (signed_op selects signed division);
// done rises 33 cycles after start and stays high until the next start; quotient/remainder valid while done.
module ex_div_iter import ex_stage_pkg::*; #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         signed_op,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    logic          busy, neg_q, neg_r, dz, ge;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a, q, b, dvd, df;
    logic [W:0]    sh;
    always_comb begin
        sh = {a, q[W-1]};
        df = sh[W-1:0] - b;
        ge = sh >= {1'b0, b};
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            a     <= '0;
            q     <= '0;
            b     <= '0;
            dvd   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            cnt   <= '0;
            a     <= '0;
            q     <= signed_op & dividend[W-1] ? -dividend : dividend;
            b     <= signed_op & divisor[W-1] ? -divisor : divisor;
            neg_q <= signed_op & (dividend[W-1] ^ divisor[W-1]);
            neg_r <= signed_op & dividend[W-1];
            dz    <= divisor == '0;
            dvd   <= dividend;
        end else if (busy) begin
            a    <= ge ? df : sh[W-1:0];
            q    <= {q[W-2:0], ge};
            cnt  <= cnt + CW'(1);
            busy <= cnt != LAST;
            done <= cnt == LAST;
        end
    // a zero divisor bypasses sign fixing so the all-ones quotient is returned unmodified
    assign quotient  = dz ? W'(DIV_ZERO_Q) : neg_q ? -q : q;
    assign remainder = dz ? dvd : neg_r ? -a : a;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage - ALU, data-SRAM request, multiplier operands, iterative divide
// Ports: clk, resetn (async active-low); id_to_ex_valid/id_to_ex_wire/ex_allowin handshake with ID;
// ex_to_mem_valid/ex_to_mem_wire/mem_allowin handshake with MEM; data_sram_* request (hand-off cycle only);
// mul_src1/mul_src2 to the shared multiplier; ex_rf_zip and ex_res_from_mem for ID forwarding and stalls.
module ex_stage import ex_stage_pkg::*; #(
    parameter int DIV_W = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       ex_allowin,
    input  logic                       id_to_ex_valid,
    input  logic [ID_TO_EX_WIDTH-1:0]  id_to_ex_wire,
    input  logic                       mem_allowin,
    output logic                       ex_to_mem_valid,
    output logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_wire,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic [32:0]                mul_src1,
    output logic [32:0]                mul_src2,
    output logic [37:0]                ex_rf_zip,
    output logic                       ex_res_from_mem
);
    id_to_ex_t        es;
    logic             ex_valid, div_started, ex_ready_go, is_div, is_ld, is_st, div_start, div_done, div_fin, handoff;
    logic [31:0]      alu_result, sra_result, div_result;
    logic [DIV_W-1:0] quotient, remainder;
    assign is_div      = es.div_w | es.mod_w | es.div_wu | es.mod_wu;
    assign is_ld       = es.ld_b | es.ld_bu | es.ld_h | es.ld_hu | es.ld_w;
    assign is_st       = es.st_b | es.st_h | es.st_w;
    assign div_start   = ex_valid & is_div & ~div_started;
    assign div_done    = div_started & div_fin;
    assign ex_ready_go = ~is_div | div_done;
    assign handoff     = ex_valid & ex_ready_go & mem_allowin;
    assign ex_allowin  = ~ex_valid | ex_ready_go & mem_allowin;
    assign ex_to_mem_valid = ex_valid & ex_ready_go;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            ex_valid    <= 1'b0;
            div_started <= 1'b0;
            es          <= '0;
        end else begin
            if (ex_allowin) ex_valid <= id_to_ex_valid;
            if (id_to_ex_valid & ex_allowin) es <= id_to_ex_wire;
            if (handoff) div_started <= 1'b0;
            else if (div_start) div_started <= 1'b1;
        end
    always_comb begin
        sra_result = $signed(es.src1) >>> es.src2[4:0];
        alu_result = {32{es.alu_op[OP_ADD]}}  & (es.src1 + es.src2)
                   | {32{es.alu_op[OP_SUB]}}  & (es.src1 - es.src2)
                   | {32{es.alu_op[OP_SLT]}}  & {31'd0, $signed(es.src1) < $signed(es.src2)}
                   | {32{es.alu_op[OP_SLTU]}} & {31'd0, es.src1 < es.src2}
                   | {32{es.alu_op[OP_AND]}}  & (es.src1 & es.src2)
                   | {32{es.alu_op[OP_NOR]}}  & ~(es.src1 | es.src2)
                   | {32{es.alu_op[OP_OR]}}   & (es.src1 | es.src2)
                   | {32{es.alu_op[OP_XOR]}}  & (es.src1 ^ es.src2)
                   | {32{es.alu_op[OP_SLL]}}  & (es.src1 << es.src2[4:0])
                   | {32{es.alu_op[OP_SRL]}}  & (es.src1 >> es.src2[4:0])
                   | {32{es.alu_op[OP_SRA]}}  & sra_result
                   | {32{es.alu_op[OP_LUI]}}  & es.src2;
    end
    ex_div_iter #(.W(DIV_W)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .signed_op (es.div_w | es.mod_w),
        .dividend  (es.src1),
        .divisor   (es.src2),
        .done      (div_fin),
        .quotient  (quotient),
        .remainder (remainder)
    );
    assign div_result = es.div_w | es.div_wu ? quotient : remainder;
    assign mul_src1 = {~es.mulh_wu & es.src1[31], es.src1};
    assign mul_src2 = {~es.mulh_wu & es.src2[31], es.src2};
    // MEM samples rdata the cycle after the request, so only a hand-off cycle may issue it
    assign data_sram_en    = ex_valid & (is_ld | is_st) & mem_allowin;
    assign data_sram_addr  = alu_result;
    assign data_sram_we    = ~(data_sram_en & is_st) ? 4'h0 : es.st_w ? 4'hF : es.st_h ? 4'b0011 << {alu_result[1], 1'b0} : 4'b0001 << alu_result[1:0];
    assign data_sram_wdata = es.st_b ? {4{es.rkd_value[7:0]}} : es.st_h ? {2{es.rkd_value[15:0]}} : es.rkd_value;
    assign ex_to_mem_wire  = {es.rf_we, es.rf_waddr, es.pc, alu_result, es.ld_b, es.ld_bu, es.ld_h, es.ld_hu, es.ld_w,
                              es.mul_w, es.mulh_w | es.mulh_wu, is_div, div_result};
    assign ex_rf_zip       = {es.rf_we & ex_valid, es.rf_waddr, alu_result};
    assign ex_res_from_mem = ex_valid & is_ld;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;
    logic clk = 1'b0;
    logic resetn, ex_allowin, id_to_ex_valid, mem_allowin, ex_to_mem_valid, data_sram_en, ex_res_from_mem;
    logic [ID_TO_EX_WIDTH-1:0]  id_to_ex_wire;
    logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_wire;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [32:0] mul_src1, mul_src2;
    logic [37:0] ex_rf_zip;
    ex_to_mem_t em;
    int checks = 0;
    int errors = 0;
    logic [11:0] alu_op_v [12] = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040, 12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h000};
    logic [31:0] alu_s1_v [12] = '{32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1, 32'h80000000, 32'h80000000, 32'h12345678, 32'h5};
    logic [31:0] alu_s2_v [12] = '{32'h7, 32'h1, 32'h1, 32'hFF00FF00, 32'h0F000000, 32'h0F00000F, 32'h0FF00FF0, 32'h24, 32'h1F, 32'h4, 32'hABCDE000, 32'h7};
    logic [31:0] alu_ex_v [12] = '{32'hFFFFFFFE, 32'h1, 32'h0, 32'hF000F000, 32'h000F0F0F, 32'hFFF0F0FF, 32'hF0F0F0F0, 32'h10, 32'h1, 32'hF8000000, 32'hABCDE000, 32'h0};
    assign em = ex_to_mem_wire;
    always #5 clk = ~clk;
    ex_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_allowin      (ex_allowin),
        .id_to_ex_valid  (id_to_ex_valid),
        .id_to_ex_wire   (id_to_ex_wire),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_wire  (ex_to_mem_wire),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .mul_src1        (mul_src1),
        .mul_src2        (mul_src2),
        .ex_rf_zip       (ex_rf_zip),
        .ex_res_from_mem (ex_res_from_mem)
    );
    function automatic id_to_ex_t mk(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2);
        id_to_ex_t b = '0;
        b.pc = 32'h1C00_0100;
        b.alu_op = op;
        b.src1 = s1;
        b.src2 = s2;
        b.rf_we = 1'b1;
        b.rf_waddr = 5'd4;
        return b;
    endfunction
    task automatic issue(input id_to_ex_t b);
        id_to_ex_wire = b;
        id_to_ex_valid = 1'b1;
        @(posedge clk); #1;
        id_to_ex_valid = 1'b0;
    endtask
    task automatic test_reset;
        resetn = 1'b0;
        id_to_ex_valid = 1'b0;
        id_to_ex_wire = '0;
        mem_allowin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ex_to_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_to_mem_valid); end
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", data_sram_en); end
        checks++; if (data_sram_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h want 0", data_sram_we); end
        checks++; if (ex_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", ex_allowin); end
        checks++; if (ex_rf_zip[37] !== 1'b0) begin errors++; $display("FAIL reset_zip_we: got %b want 0", ex_rf_zip[37]); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask
    task automatic test_add;
        issue(mk(12'h001, 32'd5, 32'd7));
        checks++; if (ex_to_mem_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", ex_to_mem_valid); end
        checks++; if (em.alu_result !== 32'd12) begin errors++; $display("FAIL add_result: got %h want 0000000c", em.alu_result); end
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL add_en: got %b want 0", data_sram_en); end
        checks++; if (ex_rf_zip !== {1'b1, 5'd4, 32'd12}) begin errors++; $display("FAIL add_zip: got %h want %h", ex_rf_zip, {1'b1, 5'd4, 32'd12}); end
        checks++; if (em.res_from_div !== 1'b0) begin errors++; $display("FAIL add_res_from_div: got %b want 0", em.res_from_div); end
        @(posedge clk); #1;
        checks++; if (ex_to_mem_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid: got %b want 0", ex_to_mem_valid); end
        checks++; if (ex_rf_zip[37] !== 1'b0) begin errors++; $display("FAIL add_drain_zip_we: got %b want 0", ex_rf_zip[37]); end
    endtask
    task automatic test_alu;
        for (int i = 0; i < 12; i++) begin
            id_to_ex_wire = mk(alu_op_v[i], alu_s1_v[i], alu_s2_v[i]);
            id_to_ex_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (ex_to_mem_valid !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d]: got %b want 1", i, ex_to_mem_valid); end
            checks++; if (em.alu_result !== alu_ex_v[i]) begin errors++; $display("FAIL alu_result[%0d]: got %h want %h", i, em.alu_result, alu_ex_v[i]); end
        end
        id_to_ex_valid = 1'b0;
        @(posedge clk); #1;
    endtask
    task automatic test_mul;
        id_to_ex_t b = mk(12'h000, 32'h8000_0000, 32'h0000_0003);
        b.mulh_wu = 1'b1;
        issue(b);
        checks++; if (mul_src1 !== 33'h0_8000_0000) begin errors++; $display("FAIL mulhu_src1: got %h want 080000000", mul_src1); end
        checks++; if (mul_src2 !== 33'h0_0000_0003) begin errors++; $display("FAIL mulhu_src2: got %h want 000000003", mul_src2); end
        checks++; if (em.mul_h !== 1'b1 || em.res_from_mul !== 1'b0) begin errors++; $display("FAIL mulhu_fields: got mul_h=%b res_from_mul=%b want 1 0", em.mul_h, em.res_from_mul); end
        b.mulh_wu = 1'b0;
        b.mul_w = 1'b1;
        issue(b);
        checks++; if (mul_src1 !== 33'h1_8000_0000) begin errors++; $display("FAIL mul_src1: got %h want 180000000", mul_src1); end
        checks++; if (em.mul_h !== 1'b0 || em.res_from_mul !== 1'b1) begin errors++; $display("FAIL mul_fields: got mul_h=%b res_from_mul=%b want 0 1", em.mul_h, em.res_from_mul); end
        @(posedge clk); #1;
    endtask
    task automatic do_div(input string name, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        id_to_ex_t b = mk(12'h000, a, d);
        int n = 0;
        int early = 0;
        {b.div_w, b.mod_w, b.div_wu, b.mod_wu} = sel;
        issue(b);
        while (!ex_allowin && n < 40) begin
            if (ex_to_mem_valid) early++;
            n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 33) begin errors++; $display("FAIL %s_cycles: got %0d want 33", name, n); end
        checks++; if (early !== 0) begin errors++; $display("FAIL %s_early_valid: got %0d cycles want 0", name, early); end
        checks++; if (ex_to_mem_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, ex_to_mem_valid); end
        checks++; if (em.div_result !== exp) begin errors++; $display("FAIL %s_result: got %h want %h", name, em.div_result, exp); end
        checks++; if (em.res_from_div !== 1'b1) begin errors++; $display("FAIL %s_res_from_div: got %b want 1", name, em.res_from_div); end
        @(posedge clk); #1;
    endtask
    task automatic test_div;
        do_div("div_w",      4'b1000, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD);
        do_div("mod_w",      4'b0100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF);
        do_div("div_wu",     4'b0010, 32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC);
        do_div("mod_wu",     4'b0001, 32'hFFFFFFF9, 32'h2,        32'h1);
        do_div("div_wu_z",   4'b0010, 32'h1234,     32'h0,        32'hFFFFFFFF);
        do_div("mod_w_z",    4'b0100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9);
        do_div("div_w_ovf",  4'b1000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        do_div("mod_w_ovf",  4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    endtask
    task automatic test_store;
        id_to_ex_t b = mk(12'h001, 32'h1000, 32'h3);
        b.st_b = 1'b1;
        b.rf_we = 1'b0;
        b.rkd_value = 32'h12345678;
        mem_allowin = 1'b0;
        issue(b);
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL stb_hold_en[%0d]: got %b want 0", i, data_sram_en); end
            checks++; if (data_sram_we !== 4'h0) begin errors++; $display("FAIL stb_hold_we[%0d]: got %h want 0", i, data_sram_we); end
            checks++; if (ex_allowin !== 1'b0) begin errors++; $display("FAIL stb_hold_allowin[%0d]: got %b want 0", i, ex_allowin); end
            @(posedge clk); #1;
        end
        mem_allowin = 1'b1;
        #1;
        checks++; if (data_sram_en !== 1'b1) begin errors++; $display("FAIL stb_en: got %b want 1", data_sram_en); end
        checks++; if (data_sram_we !== 4'b1000) begin errors++; $display("FAIL stb_we: got %b want 1000", data_sram_we); end
        checks++; if (data_sram_wdata !== 32'h78787878) begin errors++; $display("FAIL stb_wdata: got %h want 78787878", data_sram_wdata); end
        checks++; if (data_sram_addr !== 32'h1003) begin errors++; $display("FAIL stb_addr: got %h want 00001003", data_sram_addr); end
        @(posedge clk); #1;
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL stb_after_en: got %b want 0", data_sram_en); end
        b.st_b = 1'b0;
        b.st_h = 1'b1;
        b.src2 = 32'h2;
        issue(b);
        checks++; if (data_sram_we !== 4'b1100) begin errors++; $display("FAIL sth_we: got %b want 1100", data_sram_we); end
        checks++; if (data_sram_wdata !== 32'h56785678) begin errors++; $display("FAIL sth_wdata: got %h want 56785678", data_sram_wdata); end
        b.st_h = 1'b0;
        b.st_w = 1'b1;
        b.src2 = 32'h4;
        issue(b);
        checks++; if (data_sram_we !== 4'hF) begin errors++; $display("FAIL stw_we: got %h want f", data_sram_we); end
        checks++; if (data_sram_wdata !== 32'h12345678) begin errors++; $display("FAIL stw_wdata: got %h want 12345678", data_sram_wdata); end
        @(posedge clk); #1;
    endtask
    task automatic test_load;
        id_to_ex_t b = mk(12'h001, 32'h2000, 32'h4);
        logic [3:0] pat = 4'b0100;
        int reqs = 0;
        b.ld_w = 1'b1;
        mem_allowin = 1'b0;
        issue(b);
        for (int i = 0; i < 4; i++) begin
            mem_allowin = pat[i];
            #1;
            if (data_sram_en) reqs++;
            checks++; if (ex_res_from_mem !== (i < 3)) begin errors++; $display("FAIL ld_res_from_mem[%0d]: got %b want %b", i, ex_res_from_mem, i < 3); end
            @(posedge clk); #1;
        end
        checks++; if (reqs !== 1) begin errors++; $display("FAIL ld_requests: got %0d want 1", reqs); end
        mem_allowin = 1'b1;
    endtask
    task automatic test_reset_mid_div;
        id_to_ex_t b = mk(12'h001, 32'd100, 32'hFFFFFFF9);
        b.div_w = 1'b1;
        mem_allowin = 1'b1;
        issue(b);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (ex_rf_zip[37] !== 1'b1) begin errors++; $display("FAIL mid_div_zip_we: got %b want 1", ex_rf_zip[37]); end
        resetn = 1'b0;
        #1;
        checks++; if (ex_to_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_div_valid: got %b want 0", ex_to_mem_valid); end
        checks++; if (ex_allowin !== 1'b1) begin errors++; $display("FAIL rst_div_allowin: got %b want 1", ex_allowin); end
        checks++; if (ex_rf_zip[37] !== 1'b0) begin errors++; $display("FAIL rst_div_zip_we: got %b want 0", ex_rf_zip[37]); end
        @(posedge clk); #1;
        resetn = 1'b1;
        do_div("div_after_rst", 4'b1000, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);
    endtask
    initial begin
        test_reset;
        test_add;
        test_alu;
        test_mul;
        test_div;
        test_store;
        test_load;
        test_reset_mid_div;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Registers the ID bundle and evaluates the one-hot ALU op. Issues the data-SRAM request, drives the shared multiplier's operands and runs signed/unsigned division on an iterative divider.
- Packs the EX→MEM bundle in the exact field order MEM unpacks, and exports a forwarding zip for ID.

Parameters:
- DIV_W, 32, divider operand width; only 32 is supported.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ex_allowin  out  1  EX can accept a new instruction this cycle
- id_to_ex_valid  in  1  ID bundle valid
- id_to_ex_wire  in  `ID_TO_EX_WIDTH (161)  {pc32, alu_op12, src1_32, src2_32, rkd_value32, rf_we, rf_waddr5, ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w, mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu}
- mem_allowin  in  1  MEM can accept
- ex_to_mem_valid  out  1  EX bundle valid
- ex_to_mem_wire  out  `EX_TO_MEM_WIDTH (110)  {rf_we, rf_waddr5, pc32, alu_result32, ld_b, ld_bu, ld_h, ld_hu, ld_w, res_from_mul, mul_h, res_from_div, div_result32}
- data_sram_en  out  1  SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address (alu_result)
- data_sram_wdata  out  32  replicated store data
- mul_src1, mul_src2  out  33  extended multiplier operands
- ex_rf_zip  out  38  {rf_we & ex_valid, rf_waddr, alu_result}
- ex_res_from_mem  out  1  ex_valid & any ld_*; ID uses it for load-use stall

Behaviour:
- Reset (async, resetn low):
  - ex_valid=0, divider idle, div_started=0.
  - Hence ex_to_mem_valid=0, data_sram_en=0, data_sram_we=0, ex_allowin=1, and zip we=0.
- Handshake:
  - ex_allowin = ~ex_valid | ex_ready_go & mem_allowin.
  - On ex_allowin: ex_valid <= id_to_ex_valid.
  - Bundle register loads when id_to_ex_valid & ex_allowin.
  - ex_to_mem_valid = ex_valid & ex_ready_go.
- ex_ready_go = ~is_div | div_done.
  - is_div is the OR of the four div/mod bits.
  - Non-divide instructions take 1 cycle.
- ALU: one-hot alu_op[11:0] = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src2[4:0].
  - lui result = src2.
  - All-zero op gives result 0.
- Multiplier:
  - mul_src1/mul_src2 = {mulh_wu ? 0 : sign, operand}.
  - The external multiplier registers the product; MEM selects the half.
  - Bundle fields: res_from_mul = mul_w, mul_h = mulh_w | mulh_wu.
- Divider (sub-module):
  - Restoring algorithm, 1 quotient bit per cycle on absolute values, signs fixed at the end.
  - start pulses when ex_valid & is_div & ~div_started; div_started then set.
  - 33 cycles from start to done: 1 setup + 32 iterations.
  - div_done is held high until EX hands off (ex_ready_go & mem_allowin). On hand-off, div_started and done clear.
  - Select: div_result = quotient for div_*, remainder for mod_*. res_from_div = is_div.
  - Remainder takes the dividend's sign.
  - Divisor 0: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed 0x80000000 / -1: quotient=0x80000000, remainder=0.
  - Reset mid-division aborts it; the divider is idle next cycle.
- Data SRAM:
  - data_sram_en = ex_valid & (ld|st) & mem_allowin. The request is issued only in the hand-off cycle, because MEM consumes rdata in the following cycle.
  - data_sram_we is zero unless data_sram_en & st:
    - st_b: 4'b0001<<addr[1:0], wdata = {4{rkd[7:0]}}.
    - st_h: 4'b0011<<{addr[1],1'b0}, wdata = {2{rkd[15:0]}}.
    - st_w: 4'hF, wdata = rkd.
  - Misaligned addresses: no exception; low address bits are used as-is.
- Stall hold: while ex_valid & ~ex_ready_go, or while mem_allowin=0, the bundle and divider operands stay stable and no SRAM request is made.
- ex_rf_zip during division carries alu_result, not the quotient. ID stalls on a valid-we EX divide via its existing logic.

Decomposition:
- mycpu_head.h:
  - `ID_TO_EX_WIDTH=161 and `EX_TO_MEM_WIDTH=110.
  - ALU op bit-index constants.
  - Divide-by-zero and overflow result constants.
- One sub-module: ex_div_iter (clk, resetn, start, signed_op, dividend, divisor → done, quotient, remainder).
- ALU stays inline in ex_stage.

Test Plan:
- add src1=5, src2=7, mem_allowin=1 → next-cycle ex_to_mem_valid=1, alu_result=12, data_sram_en=0.
- div_w 0xFFFFFFF9 / 2 → ex_allowin=0 for 33 cycles, then div_result=0xFFFFFFFD; mod_w with the same operands → 0xFFFFFFFF.
- div_wu x / 0 → quotient 0xFFFFFFFF; div_w 0x80000000 / 0xFFFFFFFF → 0x80000000; mod_w → 0.
- st_b addr=0x1003, rkd=0x12345678 → data_sram_we=4'b1000, wdata=0x78787878, en only in hand-off cycle. mem_allowin=0 for 3 cycles → en=0 throughout.
- ld_w followed by mem_allowin toggling → ex_res_from_mem=1 while held; a single SRAM request per load.
- resetn low for 1 cycle, 10 cycles into a division → ex_valid=0 immediately; a new div afterward completes with correct result in 33 cycles.
